// File: rtl/phase_pkg.sv
// phase_pkg: phase bit indices, sequencer states and phase decode shared by the core
package phase_pkg;
    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_N = 5;
    typedef enum logic [2:0] {S_IDLE, S_FWAIT, S_F, S_R, S_X, S_M, S_W} seq_state_t;
    function automatic logic [PH_N-1:0] phase_of(seq_state_t s);
        logic [PH_N-1:0] p;
        p = '0;
        case (s)
            S_F: p[PH_F] = 1'b1;
            S_R: p[PH_R] = 1'b1;
            S_X: p[PH_X] = 1'b1;
            S_M: p[PH_M] = 1'b1;
            S_W: p[PH_W] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction
endpackage

// File: rtl/phase_seq_if.sv
// phase_seq_if: control inputs and phase/status outputs of the phase sequencer
interface phase_seq_if
    import phase_pkg::*;
#(
    parameter int ICNT_W = 32
);
    logic start;
    logic halt_req;
    logic mem_op;
    logic is_halt;
    logic mem_ack;
    logic [PH_N-1:0] phase;
    logic mem_req;
    logic running;
    logic [ICNT_W-1:0] icount;
    modport master(
        output start, halt_req, mem_op, is_halt, mem_ack,
        input phase, mem_req, running, icount
    );
    modport slave(
        input start, halt_req, mem_op, is_halt, mem_ack,
        output phase, mem_req, running, icount
    );
endinterface

// File: rtl/phase_seq.sv
// phase_seq: five-phase one-hot sequencer with memory stalls, M skipping and run/halt control
module phase_seq
    import phase_pkg::*;
#(
    parameter bit SKIP_M = 1'b1,
    parameter int ICNT_W = 32
) (
    input logic clk,
    input logic rst,
    phase_seq_if.slave bus
);
    seq_state_t state_q, state_d;
    logic mop_q, mop_d;
    logic hlt_q, hlt_d;
    logic halt_pend_q, halt_pend_d;
    logic [ICNT_W-1:0] icount_q, icount_d;
    logic running;

    assign running = state_q != S_IDLE;

    always_comb begin
        state_d = state_q;
        mop_d = mop_q;
        hlt_d = hlt_q;
        icount_d = icount_q;
        case (state_q)
            S_IDLE:  state_d = bus.start ? S_FWAIT : S_IDLE;
            S_FWAIT: state_d = bus.mem_ack ? S_F : S_FWAIT;
            S_F:     state_d = S_R;
            S_R:     state_d = S_X;
            S_X: begin
                mop_d = bus.mem_op;
                hlt_d = bus.is_halt;
                state_d = (bus.mem_op || !SKIP_M) ? S_M : S_W;
            end
            // a non-memory M is a fixed single cycle, so ack only matters for data accesses
            S_M:     state_d = (!mop_q || bus.mem_ack) ? S_W : S_M;
            S_W: begin
                icount_d = icount_q + ICNT_W'(1);
                state_d = (hlt_q || halt_pend_q || bus.halt_req) ? S_IDLE : S_FWAIT;
            end
            default: state_d = S_IDLE;
        endcase
        halt_pend_d = (state_d == S_IDLE) ? 1'b0 : (halt_pend_q || (running && bus.halt_req));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mop_q <= 1'b0;
            hlt_q <= 1'b0;
            halt_pend_q <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q <= state_d;
            mop_q <= mop_d;
            hlt_q <= hlt_d;
            halt_pend_q <= halt_pend_d;
            icount_q <= icount_d;
        end
    end

    assign bus.phase = phase_of(state_q);
    assign bus.mem_req = (state_q == S_FWAIT) || (state_q == S_M && mop_q);
    assign bus.running = running;
    assign bus.icount = icount_q;
endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: instruction-level reference model driving randomized traffic into both SKIP_M variants
module tb_phase_seq;
    import phase_pkg::*;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic start = 1'b0, halt_req = 1'b0, mem_op = 1'b0, is_halt = 1'b0, mem_ack = 1'b0;
    always #5 clk = ~clk;

    phase_seq_if #(.ICNT_W(32)) if1();
    phase_seq_if #(.ICNT_W(32)) if0();
    assign if1.start = start;
    assign if1.halt_req = halt_req;
    assign if1.mem_op = mem_op;
    assign if1.is_halt = is_halt;
    assign if1.mem_ack = mem_ack;
    assign if0.start = start;
    assign if0.halt_req = halt_req;
    assign if0.mem_op = mem_op;
    assign if0.is_halt = is_halt;
    assign if0.mem_ack = mem_ack;

    phase_seq #(.SKIP_M(1'b1), .ICNT_W(32)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
    phase_seq #(.SKIP_M(1'b0), .ICNT_W(32)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));

    bit sel = 1'b1;
    bit sk = 1'b1;
    logic [4:0] a_phase;
    logic a_mem_req, a_running;
    logic [31:0] a_icount;
    assign a_phase = sel ? if1.phase : if0.phase;
    assign a_mem_req = sel ? if1.mem_req : if0.mem_req;
    assign a_running = sel ? if1.running : if0.running;
    assign a_icount = sel ? if1.icount : if0.icount;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit log_en = 1'b0;
    bit hseen = 1'b0;
    logic [4:0] e_phase;
    logic e_mr, e_run;
    logic [31:0] cnt = '0;
    logic [4:0] plog[$];
    logic [4:0] exp_log [16] = '{5'h00, 5'h00, 5'h01, 5'h02, 5'h04, 5'h10,
                                 5'h00, 5'h01, 5'h02, 5'h04, 5'h10,
                                 5'h00, 5'h01, 5'h02, 5'h04, 5'h10};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", 32'(a_phase), 32'(e_phase));
            check("mem_req", 32'(a_mem_req), 32'(e_mr));
            check("running", 32'(a_running), 32'(e_run));
            check("icount", a_icount, cnt);
            if (log_en) plog.push_back(a_phase);
        end
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic step(input logic [4:0] ph, input logic mr, input logic run, input logic ack,
                        input logic hr, input logic st, input logic mo, input logic ih);
        e_phase = ph;
        e_mr = mr;
        e_run = run;
        mem_ack = ack;
        halt_req = hr;
        start = st;
        mem_op = mo;
        is_halt = ih;
        if (hr && run) hseen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // idle cycles with noise on halt_req/mem_ack, then one start cycle
    task automatic start_seq(input int n);
        for (int i = 0; i < n; i++) step(5'h00, 1'b0, 1'b0, rb(), rb(), 1'b0, rb(), rb());
        step(5'h00, 1'b0, 1'b0, rb(), rb(), 1'b1, rb(), rb());
    endtask

    // fw fetch-wait cycles, dw data-wait cycles, hr_at: 0 none, 1..6 = FWAIT,F,R,X,M,W
    task automatic instr(input int fw, input logic mop, input int dw, input logic ih, input int hr_at);
        hseen = 1'b0;
        for (int i = 0; i <= fw; i++)
            step(5'h00, 1'b1, 1'b1, i == fw, hr_at == 1 && i == 0, rb(), rb(), rb());
        step(5'h01, 1'b0, 1'b1, rb(), hr_at == 2, rb(), rb(), rb());
        step(5'h02, 1'b0, 1'b1, rb(), hr_at == 3, rb(), rb(), rb());
        step(5'h04, 1'b0, 1'b1, rb(), hr_at == 4, rb(), mop, ih);
        if (mop || !sk)
            for (int i = 0; i <= (mop ? dw : 0); i++)
                step(5'h08, mop, 1'b1, mop ? (i == dw) : rb(), hr_at == 5 && i == 0, rb(), rb(), rb());
        step(5'h10, 1'b0, 1'b1, rb(), hr_at == 6, rb(), rb(), rb());
        cnt++;
        if (hseen || ih) start_seq($urandom_range(3, 0));
    endtask

    task automatic rand_instr();
        int fw, dw, hr;
        fw = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 1) : 0;
        dw = ($urandom_range(0, 2) == 0) ? $urandom_range(3, 1) : 0;
        hr = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 1) : 0;
        instr(fw, rb(), dw, $urandom_range(0, 15) == 0, hr);
    endtask

    task automatic set_rst(input logic v);
        if (sel) rst1 = v;
        else rst0 = v;
    endtask

    // async reset in the middle of a data-M stall, then ack noise must not leave IDLE
    task automatic rst_test();
        step(5'h00, 1'b1, 1'b1, 1'b1, 1'b0, rb(), rb(), rb());
        step(5'h01, 1'b0, 1'b1, rb(), 1'b0, rb(), rb(), rb());
        step(5'h02, 1'b0, 1'b1, rb(), 1'b0, rb(), rb(), rb());
        step(5'h04, 1'b0, 1'b1, rb(), 1'b0, rb(), 1'b1, 1'b0);
        step(5'h08, 1'b1, 1'b1, 1'b0, 1'b0, rb(), rb(), rb());
        chk_en = 1'b0;
        mem_ack = 1'b0;
        check("pre_rst_mem_req", 32'(a_mem_req), 32'd1);
        check("pre_rst_icount", a_icount, cnt);
        #1 set_rst(1'b1);
        #1;
        check("midrst_phase", 32'(a_phase), 32'd0);
        check("midrst_mem_req", 32'(a_mem_req), 32'd0);
        check("midrst_running", 32'(a_running), 32'd0);
        check("midrst_icount", a_icount, 32'd0);
        @(posedge clk);
        #2 set_rst(1'b0);
        cnt = '0;
        chk_en = 1'b1;
        repeat (3) step(5'h00, 1'b0, 1'b0, 1'b1, rb(), 1'b0, rb(), rb());
        start_seq(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;
        check("rst_phase", 32'(a_phase), 32'd0);
        check("rst_mem_req", 32'(a_mem_req), 32'd0);
        check("rst_running", 32'(a_running), 32'd0);
        check("rst_icount", a_icount, 32'd0);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) step(5'h00, 1'b0, 1'b0, rb(), rb(), 1'b0, rb(), rb());
        log_en = 1'b1;
        start_seq(0);
        repeat (3) instr(0, 1'b0, 0, 1'b0, 0);
        log_en = 1'b0;
        check("log_len", plog.size(), 32'd16);
        for (int i = 0; i < 16 && i < plog.size(); i++)
            check($sformatf("log%0d", i), 32'(plog[i]), 32'(exp_log[i]));
        check("icount_after_3", a_icount, 32'd3);
        instr(3, 1'b0, 0, 1'b0, 0);
        instr(0, 1'b1, 2, 1'b0, 0);
        instr(0, 1'b0, 0, 1'b1, 0);
        instr(0, 1'b0, 0, 1'b0, 3);
        instr(0, 1'b0, 0, 1'b0, 6);
        instr(1, 1'b1, 1, 1'b0, 5);
        rst_test();
        repeat (150) rand_instr();
        chk_en = 1'b0;
        rst1 = 1'b1;
        sel = 1'b0;
        sk = 1'b0;
        @(posedge clk);
        #1 rst0 = 1'b0;
        cnt = '0;
        chk_en = 1'b1;
        start_seq(1);
        instr(0, 1'b0, 0, 1'b0, 0);
        instr(0, 1'b1, 1, 1'b0, 0);
        instr(0, 1'b0, 0, 1'b0, 5);
        rst_test();
        repeat (100) rand_instr();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
